// File: rtl/univ_shift_reg_if.sv
// Command/status bundle for univ_shift_reg; rot exists only when USR_ROTATE_EN is defined.
// master drives commands and data, slave (the register) returns q, serial outs, cnt and full.
interface univ_shift_reg_if #(
   parameter int WIDTH = 8
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             en;
   logic [1:0]       mode;
   logic             sin_r;
   logic             sin_l;
   logic [WIDTH-1:0] d;
`ifdef USR_ROTATE_EN
   logic             rot;
`endif
   logic [WIDTH-1:0] q;
   logic             sout_r;
   logic             sout_l;
   logic [CNT_W-1:0] cnt;
   logic             full;

   modport master (
`ifdef USR_ROTATE_EN
      output rot,
`endif
      output en, mode, sin_r, sin_l, d,
      input  q, sout_r, sout_l, cnt, full
   );

   modport slave (
`ifdef USR_ROTATE_EN
      input  rot,
`endif
      input  en, mode, sin_r, sin_l, d,
      output q, sout_r, sout_l, cnt, full
   );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / load, saturating shift counter.
// Latency: one cycle from sampled command to q and cnt; serial outs and full follow q/cnt directly.
// No backpressure: en=0 freezes all state; USR_ROTATE_EN adds bus.rot to recirculate the end bit.
module univ_shift_reg #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic            clk,
   input  logic            rst,
   univ_shift_reg_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_SHR   = 2'b01;
   localparam logic [1:0] MODE_SHL   = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   logic [WIDTH-1:0] r_q;
   logic [CNT_W-1:0] r_cnt;

   logic             w_fill_r;
   logic             w_fill_l;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [WIDTH-1:0] w_q_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;

   // Bit entering each end: serial input, or the opposite end bit when rotating.
   always_comb begin
      w_fill_r = bus.sin_r;
      w_fill_l = bus.sin_l;
`ifdef USR_ROTATE_EN
      if (bus.rot) begin
         w_fill_r = r_q[0];
         w_fill_l = r_q[WIDTH-1];
      end
`endif
   end

   assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

   always_comb begin
      w_q_nxt   = r_q;
      w_cnt_nxt = r_cnt;
      case (bus.mode)
         MODE_HOLD: begin
            w_q_nxt   = r_q;
            w_cnt_nxt = r_cnt;
         end
         MODE_SHR: begin
            w_q_nxt   = {w_fill_r, r_q[WIDTH-1:1]};
            w_cnt_nxt = w_cnt_inc;
         end
         MODE_SHL: begin
            w_q_nxt   = {r_q[WIDTH-2:0], w_fill_l};
            w_cnt_nxt = w_cnt_inc;
         end
         MODE_LOAD: begin
            w_q_nxt   = bus.d;
            w_cnt_nxt = '0;
         end
         default: begin
            w_q_nxt   = r_q;
            w_cnt_nxt = r_cnt;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q   <= RST_VAL;
         r_cnt <= '0;
      end else if (bus.en) begin
         r_q   <= w_q_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

   assign bus.q      = r_q;
   assign bus.sout_r = r_q[0];
   assign bus.sout_l = r_q[WIDTH-1];
   assign bus.cnt    = r_cnt;
   assign bus.full   = (r_cnt == CNT_MAX);
endmodule
